maze_renderer: RTL and testbench

MAZE_RENDERER -- requirements
Module: maze_renderer

---
 rtl/maze_renderer_pkg.sv | 21 ++
 rtl/pixel_skid_buffer.sv | 54 +++++
 rtl/maze_renderer.sv | 221 ++++++++++++++++++++++
 tb/tb_maze_renderer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_renderer_pkg.sv
// Shared maze definitions: geometry helpers, bus widths, colours and the renderer state type.
package maze_renderer_pkg;

  localparam int unsigned AddrW  = 11;
  localparam int unsigned CoordW = 8;
  localparam int unsigned PixW   = 16;
  localparam int unsigned BufW   = PixW + 2;

  localparam logic [PixW-1:0] ColorPlayer = 16'hF800;
  localparam logic [PixW-1:0] ColorExit   = 16'h07E0;
  localparam logic [PixW-1:0] ColorWall   = 16'h0000;
  localparam logic [PixW-1:0] ColorFloor  = 16'hFFFF;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  // Cells are separated by wall bits, so n cells span 2n+1 grid bits.
  function automatic int unsigned grid_dim(input int unsigned cells);
    return 2 * cells + 1;
  endfunction

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry elastic buffer between the colour pipeline and the pixel stream output.
module pixel_skid_buffer #(
  parameter int unsigned Width = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic             last_entry
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             push, pop;

  assign in_ready   = (count_q != 2'd2);
  assign out_valid  = (count_q != 2'd0);
  assign last_entry = (count_q == 2'd1);
  assign out_data   = mem_q[rd_ptr_q];
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/maze_renderer.sv
// Streams a maze bitmap as RGB565 pixels in raster order, one grid bit per TILE x TILE block.
module maze_renderer
  import maze_renderer_pkg::*;
#(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned HEIGHT = 2,
  parameter int unsigned TILE   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              gen_end,
  input  logic [CoordW-1:0] player_x,
  input  logic [CoordW-1:0] player_y,
  output logic [AddrW-1:0]  maze_address,
  input  logic              maze_address_data,
  output logic [PixW-1:0]   pixel_data,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              pixel_sof,
  output logic              pixel_eol,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned GW    = grid_dim(WIDTH);
  localparam int unsigned GH    = grid_dim(HEIGHT);
  localparam int unsigned ColW  = CoordW + 1;
  localparam int unsigned TileW = (TILE > 1) ? $clog2(TILE) : 1;

  localparam logic [ColW-1:0]  LastCol  = ColW'(GW - 1);
  localparam logic [ColW-1:0]  LastRow  = ColW'(GH - 1);
  localparam logic [ColW-1:0]  ExitCol  = ColW'(GW - 2);
  localparam logic [ColW-1:0]  ExitRow  = ColW'(GH - 2);
  localparam logic [TileW-1:0] LastTile = TileW'(TILE - 1);
  localparam logic [AddrW-1:0] RowStep  = AddrW'(GW);

  state_e            state_q, state_d;
  logic [TileW-1:0]  tx_q, tx_d, ty_q, ty_d;
  logic [ColW-1:0]   col_q, col_d, row_q, row_d;
  logic [ColW-1:0]   pcol_q, pcol_d, prow_q, prow_d;
  logic [AddrW-1:0]  row_base_q, row_base_d, addr_q, addr_d;
  logic              a_valid_q, a_valid_d;
  logic              b_valid_q, b_valid_d, b_fresh_q, b_fresh_d;
  logic              b_player_q, b_player_d, b_exit_q, b_exit_d;
  logic              b_sof_q, b_sof_d, b_eol_q, b_eol_d;
  logic              wall_hold_q, wall_hold_d;
  logic              frame_done_q, frame_done_d;

  logic              a_sof, a_eol, a_last, accept, advance, final_pop, wall_b;
  logic              buf_in_ready, buf_last, buf_flush;
  logic [PixW-1:0]   color;
  logic [BufW-1:0]   buf_out;

  assign a_sof  = (tx_q == '0) && (col_q == '0) && (ty_q == '0) && (row_q == '0);
  assign a_eol  = (tx_q == LastTile) && (col_q == LastCol);
  assign a_last = a_eol && (ty_q == LastTile) && (row_q == LastRow);
  assign accept = (state_q == StIdle) && frame_start && gen_end;
  // Stage B only moves when its pixel can enter the buffer; stage A follows it.
  assign advance   = !b_valid_q || buf_in_ready;
  assign buf_flush = (state_q != StIdle) && !gen_end;
  assign final_pop = (state_q == StDrain) && !b_valid_q && pixel_valid && pixel_ready && buf_last;
  // The memory keeps reading the held stage-A address during a stall, so keep B's bit.
  assign wall_b    = b_fresh_q ? maze_address_data : wall_hold_q;

  always_comb begin
    if (b_player_q)    color = ColorPlayer;
    else if (b_exit_q) color = ColorExit;
    else if (wall_b)   color = ColorWall;
    else               color = ColorFloor;
  end

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
    col_d        = col_q;
    row_d        = row_q;
    pcol_d       = pcol_q;
    prow_d       = prow_q;
    row_base_d   = row_base_q;
    addr_d       = addr_q;
    a_valid_d    = a_valid_q;
    b_valid_d    = b_valid_q;
    b_fresh_d    = b_fresh_q;
    b_player_d   = b_player_q;
    b_exit_d     = b_exit_q;
    b_sof_d      = b_sof_q;
    b_eol_d      = b_eol_q;
    wall_hold_d  = wall_hold_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StRun;
          tx_d       = '0;
          ty_d       = '0;
          col_d      = '0;
          row_d      = '0;
          row_base_d = '0;
          addr_d     = '0;
          a_valid_d  = 1'b1;
          pcol_d     = {player_x, 1'b1};
          prow_d     = {player_y, 1'b1};
        end
      end
      StRun, StDrain: begin
        if (advance) begin
          b_valid_d  = a_valid_q;
          b_fresh_d  = 1'b1;
          b_player_d = (col_q == pcol_q) && (row_q == prow_q);
          b_exit_d   = (col_q == ExitCol) && (row_q == ExitRow);
          b_sof_d    = a_sof;
          b_eol_d    = a_eol;
          if (a_valid_q) begin
            if (a_last) begin
              a_valid_d = 1'b0;
              state_d   = StDrain;
            end else begin
              if (tx_q != LastTile) begin
                tx_d = tx_q + TileW'(1);
              end else begin
                tx_d = '0;
                if (col_q != LastCol) begin
                  col_d = col_q + ColW'(1);
                end else begin
                  col_d = '0;
                  if (ty_q != LastTile) begin
                    ty_d = ty_q + TileW'(1);
                  end else begin
                    ty_d       = '0;
                    row_d      = row_q + ColW'(1);
                    row_base_d = row_base_q + RowStep;
                  end
                end
              end
              addr_d = row_base_d + AddrW'(col_d);
            end
          end
        end else begin
          wall_hold_d = wall_b;
          b_fresh_d   = 1'b0;
        end
        if (final_pop) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end
        if (!gen_end) begin
          state_d      = StIdle;
          a_valid_d    = 1'b0;
          b_valid_d    = 1'b0;
          frame_done_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      tx_q         <= '0;
      ty_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      pcol_q       <= '0;
      prow_q       <= '0;
      row_base_q   <= '0;
      addr_q       <= '0;
      a_valid_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      b_fresh_q    <= 1'b0;
      b_player_q   <= 1'b0;
      b_exit_q     <= 1'b0;
      b_sof_q      <= 1'b0;
      b_eol_q      <= 1'b0;
      wall_hold_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pcol_q       <= pcol_d;
      prow_q       <= prow_d;
      row_base_q   <= row_base_d;
      addr_q       <= addr_d;
      a_valid_q    <= a_valid_d;
      b_valid_q    <= b_valid_d;
      b_fresh_q    <= b_fresh_d;
      b_player_q   <= b_player_d;
      b_exit_q     <= b_exit_d;
      b_sof_q      <= b_sof_d;
      b_eol_q      <= b_eol_d;
      wall_hold_q  <= wall_hold_d;
      frame_done_q <= frame_done_d;
    end
  end

  pixel_skid_buffer #(
    .Width(BufW)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (buf_flush),
    .in_valid  (b_valid_q),
    .in_ready  (buf_in_ready),
    .in_data   ({color, b_sof_q, b_eol_q}),
    .out_valid (pixel_valid),
    .out_ready (pixel_ready),
    .out_data  (buf_out),
    .last_entry(buf_last)
  );

  assign {pixel_data, pixel_sof, pixel_eol} = buf_out;
  assign maze_address = addr_q;
  assign busy         = (state_q != StIdle);
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_maze_renderer.sv
// Directed bench for maze_renderer at WIDTH=5, HEIGHT=2, TILE=2 (22x10 pixel frame).
module tb_maze_renderer;

  localparam int NPix  = 220;
  localparam int Cells = 55;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        gen_end = 1'b1;
  logic [7:0]  player_x = '0;
  logic [7:0]  player_y = '0;
  logic [10:0] maze_address;
  logic        maze_address_data;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready = 1'b1;
  logic        pixel_sof, pixel_eol, busy, frame_done;

  maze_renderer #(
    .WIDTH (5),
    .HEIGHT(2),
    .TILE  (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .frame_start      (frame_start),
    .gen_end          (gen_end),
    .player_x         (player_x),
    .player_y         (player_y),
    .maze_address     (maze_address),
    .maze_address_data(maze_address_data),
    .pixel_data       (pixel_data),
    .pixel_valid      (pixel_valid),
    .pixel_ready      (pixel_ready),
    .pixel_sof        (pixel_sof),
    .pixel_eol        (pixel_eol),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  always #5 clock = ~clock;

  logic mem [Cells];
  always @(posedge clock)
    maze_address_data <= (maze_address < 11'd55) ? mem[int'(maze_address)] : 1'b0;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, start_cyc = 0, first_valid_cyc = -1;
  int n_xfer = 0, done_cnt = 0, done_cyc = 0, stall_err = 0, addr_bad = 0, base = 0;
  bit stall_chk = 0, rand_ready = 0, prev_stall = 0;
  logic [17:0] prev_out = '0;
  logic [15:0] rec_data [256];
  logic        rec_sof [256];
  logic        rec_eol [256];
  logic [15:0] ref_data [NPix];

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) if (rand_ready) #1 pixel_ready = 1'($urandom_range(0, 1));

  always @(negedge clock) begin
    if (maze_address > 11'd54) addr_bad++;
    if (pixel_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (stall_chk && prev_stall &&
        (!pixel_valid || {pixel_data, pixel_sof, pixel_eol} != prev_out)) stall_err++;
    prev_stall = pixel_valid && !pixel_ready;
    prev_out   = {pixel_data, pixel_sof, pixel_eol};
    if (pixel_valid && pixel_ready) begin
      if (n_xfer < 256) begin
        rec_data[n_xfer] = pixel_data;
        rec_sof[n_xfer]  = pixel_sof;
        rec_eol[n_xfer]  = pixel_eol;
      end
      n_xfer++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required less", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_border(input int col, input int row);
    return (col == 0) || (col == 10) || (row == 0) || (row == 4);
  endfunction

  function automatic logic [15:0] model_pix(input int idx, input bit walls, input int plx,
                                            input int ply);
    int col, row;
    col = (idx % 22) / 2;
    row = (idx / 22) / 2;
    if (col == 2 * plx + 1 && row == 2 * ply + 1) return 16'hF800;
    if (col == 9 && row == 3) return 16'h07E0;
    if (walls && is_border(col, row)) return 16'h0000;
    return 16'hFFFF;
  endfunction

  task automatic load_maze(input bit walls);
    for (int c = 0; c < Cells; c++) mem[c] = walls && is_border(c % 11, c / 11);
  endtask

  task automatic start_frame(input int plx, input int ply);
    @(posedge clock);
    #1;
    player_x        = 8'(plx);
    player_y        = 8'(ply);
    frame_start     = 1'b1;
    n_xfer          = 0;
    first_valid_cyc = -1;
    base            = done_cnt;
    @(posedge clock);
    #1;
    start_cyc   = cyc;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == base; i++) @(negedge clock);
  endtask

  task automatic check_seq(input string tag, input bit walls, input int plx, input int ply);
    int bad = 0;
    for (int i = 0; i < NPix; i++) begin
      if (rec_data[i] !== model_pix(i, walls, plx, ply)) bad++;
      if (rec_sof[i] !== (i == 0)) bad++;
      if (rec_eol[i] !== (i % 22 == 21)) bad++;
    end
    check_value(tag, bad, 0);
  endtask

  initial begin
    int bad;
    load_maze(1'b0);
    repeat (3) @(posedge clock);
    #1;
    check_value("rst_valid", pixel_valid, 0);
    check_value("rst_data", pixel_data, 0);
    check_value("rst_addr", maze_address, 0);
    check_value("rst_flags", {busy, frame_done, pixel_sof, pixel_eol}, 0);
    @(negedge clock) reset = 1'b1;

    // Open maze, player at cell (0,0)
    start_frame(0, 0);
    wait_done(400);
    check_value("t1_latency", first_valid_cyc - start_cyc, 2);
    check_value("t1_sof0", rec_sof[0], 1);
    check_value("t1_data0", rec_data[0], 16'hFFFF);
    check_value("t1_player_2_2", rec_data[2 * 22 + 2], 16'hF800);
    check_value("t1_player_3_2", rec_data[2 * 22 + 3], 16'hF800);
    check_value("t1_player_2_3", rec_data[3 * 22 + 2], 16'hF800);
    check_value("t1_player_3_3", rec_data[3 * 22 + 3], 16'hF800);
    check_value("t1_count", n_xfer, NPix);
    check_value("t1_done_lat", done_cyc - start_cyc, 222);
    check_value("t1_done_cnt", done_cnt - base, 1);
    check_value("t1_busy_end", busy, 0);
    check_seq("t1_seq", 1'b0, 0, 0);
    for (int i = 0; i < NPix; i++) ref_data[i] = rec_data[i];

    // Border walls; player inputs change after acceptance and must be ignored
    load_maze(1'b1);
    start_frame(3, 1);
    player_x = 8'd0;
    player_y = 8'd2;
    wait_done(400);
    bad = 0;
    for (int i = 0; i < 22; i++) if (rec_data[i] !== 16'h0000) bad++;
    for (int y = 0; y < 10; y++) if (rec_data[y * 22] !== 16'h0000) bad++;
    check_value("t2_border", bad, 0);
    bad = 0;
    for (int y = 6; y < 8; y++)
      for (int x = 18; x < 20; x++) if (rec_data[y * 22 + x] !== 16'h07E0) bad++;
    check_value("t2_exit", bad, 0);
    check_value("t2_player", rec_data[6 * 22 + 14], 16'hF800);
    bad = 0;
    for (int i = 0; i < NPix; i++) if (rec_eol[i] !== (i % 22 == 21)) bad++;
    check_value("t2_eol", bad, 0);
    check_value("t2_count", n_xfer, NPix);
    check_seq("t2_seq", 1'b1, 3, 1);

    // Random backpressure
    load_maze(1'b0);
    stall_chk  = 1'b1;
    rand_ready = 1'b1;
    start_frame(0, 0);
    wait_done(2000);
    rand_ready = 1'b0;
    stall_chk  = 1'b0;
    @(posedge clock);
    #2 pixel_ready = 1'b1;
    check_value("t3_count", n_xfer, NPix);
    check_value("t3_done_cnt", done_cnt - base, 1);
    bad = 0;
    for (int i = 0; i < NPix; i++) if (rec_data[i] !== ref_data[i]) bad++;
    check_value("t3_seq", bad, 0);
    check_value("t3_stall_stable", stall_err, 0);

    // Abort by gen_end falling 50 cycles in
    start_frame(0, 0);
    repeat (50) @(posedge clock);
    #1 gen_end = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_value("t4_valid_drop", pixel_valid, 0);
    check_value("t4_busy", busy, 0);
    repeat (10) @(negedge clock);
    check_value("t4_no_done", done_cnt - base, 0);
    check_value("t4_xfers", n_xfer, 49);
    gen_end = 1'b1;
    start_frame(0, 0);
    wait_done(400);
    check_value("t4_refill_count", n_xfer, NPix);
    check_value("t4_refill_done", done_cnt - base, 1);
    check_seq("t4_refill_seq", 1'b0, 0, 0);

    // Asynchronous reset around pixel 100
    start_frame(0, 0);
    for (int i = 0; i < 400 && n_xfer < 100; i++) @(negedge clock);
    check_value("t5_reached_100", n_xfer >= 100, 1);
    #2 reset = 1'b0;
    #1;
    check_value("t5_rst_flags", {pixel_valid, pixel_sof, pixel_eol, busy, frame_done}, 0);
    check_value("t5_rst_data", pixel_data, 0);
    check_value("t5_rst_addr", maze_address, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    start_frame(0, 0);
    wait_done(400);
    check_value("t5_latency", first_valid_cyc - start_cyc, 2);
    check_value("t5_sof0", rec_sof[0], 1);
    check_value("t5_data0", rec_data[0], 16'hFFFF);
    check_value("t5_count", n_xfer, NPix);

    // frame_start while busy and on the final-transfer edge
    start_frame(0, 0);
    repeat (20) @(posedge clock);
    #1 frame_start = 1'b1;
    @(posedge clock);
    #1 frame_start = 1'b0;
    repeat (200) @(posedge clock);
    #1 frame_start = 1'b1;
    @(posedge clock);
    #1 frame_start = 1'b0;
    repeat (10) @(negedge clock);
    check_value("t6_busy_after", busy, 0);
    check_value("t6_done_cnt", done_cnt - base, 1);
    check_value("t6_count", n_xfer, NPix);
    bad = 0;
    for (int i = 0; i < NPix; i++) bad += int'(rec_sof[i]);
    check_value("t6_one_sof", bad, 1);

    // frame_start ignored while gen_end is low
    gen_end = 1'b0;
    @(posedge clock);
    #1 frame_start = 1'b1;
    @(posedge clock);
    #1 frame_start = 1'b0;
    repeat (5) @(negedge clock);
    check_value("t6_gen_low_busy", busy, 0);
    check_value("t6_gen_low_xfers", n_xfer, NPix);
    check_value("t6_gen_low_done", done_cnt - base, 1);
    gen_end = 1'b1;

    check_value("addr_range", addr_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
